// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch, decode, execute, memory, writeback, trap and halt.
// Emits per-state datapath strobes and counts retired instructions.
module control_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_load,
  input  logic        dec_illegal,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_branch,
  input  logic        dec_jump,
  input  logic        dec_fence,
  input  logic        dec_ecall,
  input  logic        dec_ebreak,
  input  logic        branch_taken,
  output logic        alu_en,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic        halted,
  input  logic        resume,
  output logic [31:0] retire_count,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b00;
  localparam logic [1:0] CAUSE_ECALL   = 2'b01;
  localparam logic [1:0] CAUSE_EBREAK  = 2'b10;

  state_t      state_q, state_d;
  logic        cls_load_q, cls_store_q, cls_branch_q, cls_jump_q, cls_fence_q;
  logic [1:0]  cause_q;
  logic [31:0] retire_q;
  logic        retire_inc;

  logic [2:0]  class_count;
  logic        multi_class;
  logic        dec_trap;
  logic [1:0]  dec_cause;

  // More than one memory/control class at once is treated as an illegal encoding.
  assign class_count = 3'(dec_load) + 3'(dec_store) + 3'(dec_branch)
                     + 3'(dec_jump) + 3'(dec_fence);
  assign multi_class = class_count > 3'd1;
  assign dec_trap    = dec_illegal | multi_class | dec_ebreak | dec_ecall;

  always_comb begin
    dec_cause = CAUSE_ILLEGAL;
    if (dec_illegal || multi_class) dec_cause = CAUSE_ILLEGAL;
    else if (dec_ebreak)            dec_cause = CAUSE_EBREAK;
    else if (dec_ecall)             dec_cause = CAUSE_ECALL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      cls_load_q   <= 1'b0;
      cls_store_q  <= 1'b0;
      cls_branch_q <= 1'b0;
      cls_jump_q   <= 1'b0;
      cls_fence_q  <= 1'b0;
      cause_q      <= CAUSE_ILLEGAL;
      retire_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        cls_load_q   <= dec_load;
        cls_store_q  <= dec_store;
        cls_branch_q <= dec_branch;
        cls_jump_q   <= dec_jump;
        cls_fence_q  <= dec_fence;
        cause_q      <= dec_cause;
      end
      if (retire_inc) retire_q <= retire_q + 32'd1;
    end
  end

  // Strobes are forced low while reset is held, independent of the stored state.
  always_comb begin
    state_d    = S_FETCH;
    retire_inc = 1'b0;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    alu_en     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'b00;
    trap       = 1'b0;
    trap_cause = 2'b00;
    halted     = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_load = 1'b1;
            state_d = S_DECODE;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DECODE: begin
          if (dec_trap)       state_d = S_TRAP;
          else if (dec_fence) state_d = S_WRITEBACK;
          else                state_d = S_EXECUTE;
        end
        S_EXECUTE: begin
          alu_en  = 1'b1;
          state_d = (cls_load_q || cls_store_q) ? S_MEMORY : S_WRITEBACK;
        end
        S_MEMORY: begin
          dmem_req = 1'b1;
          dmem_we  = cls_store_q;
          state_d  = dmem_ack ? S_WRITEBACK : S_MEMORY;
        end
        S_WRITEBACK: begin
          pc_we      = 1'b1;
          pc_sel     = (cls_jump_q || (cls_branch_q && branch_taken)) ? 2'b01 : 2'b00;
          rf_we      = !(cls_store_q || cls_branch_q || cls_fence_q);
          retire_inc = 1'b1;
          state_d    = S_FETCH;
        end
        S_TRAP: begin
          trap       = 1'b1;
          pc_we      = 1'b1;
          pc_sel     = 2'b10;
          trap_cause = cause_q;
          state_d    = (cause_q == CAUSE_EBREAK) ? S_HALT : S_FETCH;
        end
        S_HALT: begin
          halted  = 1'b1;
          state_d = resume ? S_FETCH : S_HALT;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign retire_count = retire_q;
  assign state        = rst_n ? state_q : S_FETCH;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer: a driver queues the expected outcome of
// each instruction from a rule-level model, a negedge monitor compares when the DUT commits.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, ir_load;
  logic        dec_illegal, dec_load, dec_store, dec_branch, dec_jump, dec_fence, dec_ecall, dec_ebreak;
  logic        branch_taken, alu_en, dmem_req, dmem_we, dmem_ack;
  logic        rf_we, pc_we, trap, halted, resume;
  logic [1:0]  pc_sel, trap_cause;
  logic [31:0] retire_count;
  logic [2:0]  state;

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
    .dec_illegal(dec_illegal), .dec_load(dec_load), .dec_store(dec_store),
    .dec_branch(dec_branch), .dec_jump(dec_jump), .dec_fence(dec_fence),
    .dec_ecall(dec_ecall), .dec_ebreak(dec_ebreak),
    .branch_taken(branch_taken), .alu_en(alu_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .trap(trap), .trap_cause(trap_cause), .halted(halted), .resume(resume),
    .retire_count(retire_count), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ill, ld, st, br, jp, fe, ec, eb, taken;
    int   fetch_delay, dmem_delay, resume_delay;
  } inst_t;

  typedef struct {
    logic        trap;
    logic [1:0]  cause;
    logic [1:0]  pc_sel;
    logic        rf_we;
    logic        mem;
    logic        we;
    logic        halts;
    logic        retires;
    int          alu;
    logic [31:0] retire;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          alu_seen = 0;
  logic        mon_en = 1'b0;
  logic [31:0] model_retire = 32'd0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Outcome of one instruction derived from the class flags and the trap priority rules.
  function automatic exp_t model(input inst_t ins, input logic [31:0] rc);
    exp_t e;
    int   n;
    n = int'(ins.ld) + int'(ins.st) + int'(ins.br) + int'(ins.jp) + int'(ins.fe);
    e.trap = 1'b0; e.cause = 2'd0; e.pc_sel = 2'd0; e.rf_we = 1'b0; e.mem = 1'b0;
    e.we = 1'b0; e.halts = 1'b0; e.retires = 1'b0; e.alu = 0; e.retire = rc;
    if (ins.ill || n > 1) begin
      e.trap = 1'b1; e.cause = 2'd0;
    end else if (ins.eb) begin
      e.trap = 1'b1; e.cause = 2'd2; e.halts = 1'b1;
    end else if (ins.ec) begin
      e.trap = 1'b1; e.cause = 2'd1;
    end
    if (e.trap) begin
      e.pc_sel = 2'd2;
    end else if (ins.fe) begin
      e.retires = 1'b1;
    end else begin
      e.alu     = 1;
      e.mem     = ins.ld | ins.st;
      e.we      = ins.st;
      e.pc_sel  = (ins.jp || (ins.br && ins.taken)) ? 2'd1 : 2'd0;
      e.rf_we   = !(ins.st || ins.br);
      e.retires = 1'b1;
    end
    return e;
  endfunction

  function automatic inst_t blank_inst();
    inst_t i;
    i.ill = 0; i.ld = 0; i.st = 0; i.br = 0; i.jp = 0; i.fe = 0; i.ec = 0; i.eb = 0; i.taken = 0;
    i.fetch_delay = 0; i.dmem_delay = 0; i.resume_delay = 0;
    return i;
  endfunction

  function automatic inst_t rand_inst();
    inst_t i;
    int    r, c1, c2;
    i = blank_inst();
    r = $urandom_range(0, 99);
    c1 = $urandom_range(0, 4);
    c2 = (c1 + $urandom_range(1, 4)) % 5;
    if (r < 15) begin end
    else if (r < 30) i.ld = 1;
    else if (r < 45) i.st = 1;
    else if (r < 57) i.br = 1;
    else if (r < 67) i.jp = 1;
    else if (r < 75) i.fe = 1;
    else if (r < 82) begin
      i.ill = 1; i.ec = 1'($urandom_range(0, 1)); i.eb = 1'($urandom_range(0, 1));
      i.ld = 1'($urandom_range(0, 1));
    end else if (r < 87) begin
      i.ec = 1; i.ld = (c1 == 0); i.br = (c1 == 2);
    end else if (r < 92) begin
      i.eb = 1; i.ec = 1'($urandom_range(0, 1)); i.st = (c1 == 1);
    end else begin
      i.ld = (c1 == 0) || (c2 == 0); i.st = (c1 == 1) || (c2 == 1); i.br = (c1 == 2) || (c2 == 2);
      i.jp = (c1 == 3) || (c2 == 3); i.fe = (c1 == 4) || (c2 == 4);
      i.eb = 1'($urandom_range(0, 1));
    end
    i.taken        = 1'($urandom_range(0, 1));
    i.fetch_delay  = $urandom_range(0, 3);
    i.dmem_delay   = $urandom_range(0, 4);
    i.resume_delay = $urandom_range(0, 3);
    return i;
  endfunction

  task automatic setDec(input inst_t ins);
    dec_illegal = ins.ill; dec_load = ins.ld; dec_store = ins.st; dec_branch = ins.br;
    dec_jump = ins.jp; dec_fence = ins.fe; dec_ecall = ins.ec; dec_ebreak = ins.eb;
  endtask

  task automatic scrambleDec();
    {dec_illegal, dec_load, dec_store, dec_branch, dec_jump, dec_fence, dec_ecall, dec_ebreak} = 8'($urandom);
  endtask

  // Runs one instruction from FETCH back to FETCH; called at posedge+1 with the DUT in FETCH.
  task automatic applyStimulus(input inst_t ins);
    exp_t e;
    int   guard, mem_cnt;
    logic saw_halt;
    guard = 0; mem_cnt = 0; saw_halt = 1'b0;
    imem_ack = 1'b0;
    while (!imem_req && guard < 50) begin @(posedge clk); #1; guard++; end
    if (!imem_req) begin
      checkOutput("fetch_wait_timeout", 32'(imem_req), 32'd1);
      return;
    end
    e = model(ins, model_retire);
    exp_q.push_back(e);
    if (e.retires) model_retire = model_retire + 32'd1;
    for (int k = 0; k < ins.fetch_delay; k++) begin
      dmem_ack = 1'($urandom_range(0, 1));
      #1 checkOutput("fetch_hold", {30'd0, imem_req, ir_load}, 32'b10);
      @(posedge clk); #1;
    end
    imem_ack = 1'b1;
    #1 checkOutput("fetch_ack_ir_load", {30'd0, imem_req, ir_load}, 32'b11);
    @(posedge clk); #1;
    imem_ack = 1'($urandom_range(0, 1));
    setDec(ins);
    branch_taken = ins.taken;
    @(posedge clk); #1;
    scrambleDec();
    imem_ack = 1'b0;
    guard = 0;
    while (guard <= 200 && !imem_req) begin
      if (halted) begin
        saw_halt = 1'b1;
        for (int k = 0; k < ins.resume_delay; k++) begin
          resume = 1'b0;
          checkOutput("halt_hold", {25'd0, halted, imem_req, pc_we, trap, alu_en, dmem_req, rf_we}, 32'b1000000);
          @(posedge clk); #1;
        end
        resume = 1'b1;
        checkOutput("halt_hold", {25'd0, halted, imem_req, pc_we, trap, alu_en, dmem_req, rf_we}, 32'b1000000);
        @(posedge clk); #1;
        resume = 1'b0;
      end else begin
        resume = 1'($urandom_range(0, 1));
        if (dmem_req) begin
          dmem_ack = (mem_cnt == ins.dmem_delay);
          mem_cnt++;
        end else begin
          dmem_ack = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
      end
      guard++;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0; resume = 1'b0;
    if (!imem_req) checkOutput("instr_timeout", 32'(guard), 32'd0);
    checkOutput("dmem_cycles", 32'(mem_cnt), e.mem ? 32'(ins.dmem_delay + 1) : 32'd0);
    checkOutput("halt_entered", 32'(saw_halt), 32'(e.halts));
  endtask

  // Monitor: commits are identified by pc_we; memory requests are checked against the pending entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !mon_en) begin
      alu_seen = 0;
    end else begin
      if (alu_en) alu_seen++;
      if (dmem_req) begin
        if (exp_q.size() == 0) checkOutput("dmem_req_idle", {30'd0, dmem_req, dmem_we}, 32'd0);
        else checkOutput("dmem_req_we", {30'd0, dmem_req, dmem_we}, {30'd0, exp_q[0].mem, exp_q[0].we});
      end
      if (pc_we) begin
        if (exp_q.size() == 0) begin
          checkOutput("pc_we_idle", 32'(pc_we), 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("commit_flags", {26'd0, trap, trap_cause, pc_sel, rf_we},
                      {26'd0, e.trap, e.cause, e.pc_sel, e.rf_we});
          checkOutput("commit_retire_count", retire_count, e.retire);
          checkOutput("alu_pulses", 32'(alu_seen), 32'(e.alu));
          alu_seen = 0;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no completion, required completion within 5 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    inst_t ins;
    exp_t  e;
    rst_n = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1; resume = 1'b1; branch_taken = 1'b1;
    scrambleDec();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {16'd0, imem_req, ir_load, alu_en, dmem_req, dmem_we, rf_we, pc_we,
                trap, halted, pc_sel, trap_cause, state}, 32'd0);
    checkOutput("reset_retire", retire_count, 32'd0);
    imem_ack = 1'b0; dmem_ack = 1'b0; resume = 1'b0; branch_taken = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    #1 checkOutput("post_reset_imem_req", 32'(imem_req), 32'd1);

    // ADD accepted in the first fetch cycle, with cycle-exact strobe timing.
    ins = blank_inst();
    e = model(ins, model_retire);
    exp_q.push_back(e);
    model_retire = model_retire + 32'd1;
    imem_ack = 1'b1;
    #1 checkOutput("add_c0_ir_load", {30'd0, imem_req, ir_load}, 32'b11);
    @(posedge clk); #1;
    imem_ack = 1'b0; setDec(ins);
    checkOutput("add_c1_decode", 32'(state), 32'd1);
    @(posedge clk); #1;
    scrambleDec();
    checkOutput("add_c2_alu_en", {28'd0, alu_en, state}, {28'd0, 1'b1, 3'd2});
    @(posedge clk); #1;
    checkOutput("add_c3_writeback", {28'd0, rf_we, pc_we, pc_sel}, 32'b1100);
    @(posedge clk); #1;
    checkOutput("add_c4_imem_req", 32'(imem_req), 32'd1);
    checkOutput("add_retire_count", retire_count, 32'd1);

    for (int n = 0; n < 250; n++) applyStimulus(rand_inst());

    // Counter wrap from all-ones.
    force dut.retire_q = 32'hFFFF_FFFF;
    #1 release dut.retire_q;
    model_retire = 32'hFFFF_FFFF;
    applyStimulus(blank_inst());
    checkOutput("retire_wrap", retire_count, 32'd0);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset while a load is waiting on its data acknowledge.
    mon_en = 1'b0;
    ins = blank_inst(); ins.ld = 1'b1;
    imem_ack = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0; setDec(ins);
    @(posedge clk); #1;
    scrambleDec();
    @(posedge clk); #1;
    checkOutput("mem_wait_req", {29'd0, dmem_req, dmem_we, state[0]}, {29'd0, 1'b1, 1'b0, 1'b1});
    @(posedge clk); #1;
    checkOutput("mem_wait_stable", {27'd0, dmem_req, dmem_we, state}, {27'd0, 1'b1, 1'b0, 3'd3});
    rst_n = 1'b0;
    #1 checkOutput("reset_comb_strobes", {23'd0, imem_req, ir_load, alu_en, dmem_req, dmem_we, rf_we,
                   pc_we, trap, halted}, 32'd0);
    @(posedge clk); #1;
    checkOutput("mid_mem_reset_state", {25'd0, state, pc_sel, trap_cause}, 32'd0);
    checkOutput("mid_mem_reset_retire", retire_count, 32'd0);
    rst_n = 1'b1;
    #1 checkOutput("mid_mem_release_imem_req", 32'(imem_req), 32'd1);
    exp_q.delete();
    model_retire = 32'd0;
    mon_en = 1'b1;
    for (int n = 0; n < 20; n++) applyStimulus(rand_inst());
    repeat (2) @(posedge clk);
    #1 checkOutput("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
